// File: rtl/temp_monitor.sv
// Four-sensor over-temperature detector: carry-save sum, divide by four, strict threshold compare.
// Optional build macro TEMP_STICKY_EN latches tooHot until rst is asserted.
module temp_monitor #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] temp1,
    input  logic [W-1:0] temp2,
    input  logic [W-1:0] temp3,
    input  logic [W-1:0] temp4,
    input  logic [W-1:0] temp_compare,
    output logic [W-1:0] temp_avg,
    output logic         tooHot
);

    localparam int SW = W + 2;

    // 3:2 compressor, sum vector
    function automatic logic [SW-1:0] csa_sum(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                              input logic [SW-1:0] c);
        return a ^ b ^ c;
    endfunction

    // 3:2 compressor, carry vector already weighted by two; the dropped MSB is always zero
    function automatic logic [SW-1:0] csa_carry(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                                input logic [SW-1:0] c);
        logic [SW-1:0] maj;
        maj = (a & b) | (a & c) | (b & c);
        return {maj[SW-2:0], 1'b0};
    endfunction

    function automatic logic [SW-1:0] ripple_add(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [SW-1:0] s;
        logic          c;
        s = {SW{1'b0}};
        c = 1'b0;
        for (int i = 0; i < SW; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return s;
    endfunction

    logic [SW-1:0] op1_s, op2_s, op3_s, op4_s;
    logic [SW-1:0] lvl1_sum_s, lvl1_carry_s;
    logic [SW-1:0] lvl2_sum_s, lvl2_carry_s;
    logic [SW-1:0] sum_s;
    logic [SW-1:0] sum_q;
    logic [W-1:0]  avg_s;
    logic          hot_s;
    logic          hot_next_s;
    logic [W-1:0]  temp_avg_r;
    logic          too_hot_r;

    // Stage 1 combinational: two CSA levels then ripple-carry resolve
    always_comb begin
        op1_s        = {2'b00, temp1};
        op2_s        = {2'b00, temp2};
        op3_s        = {2'b00, temp3};
        op4_s        = {2'b00, temp4};
        lvl1_sum_s   = csa_sum(op1_s, op2_s, op3_s);
        lvl1_carry_s = csa_carry(op1_s, op2_s, op3_s);
        lvl2_sum_s   = csa_sum(lvl1_sum_s, lvl1_carry_s, op4_s);
        lvl2_carry_s = csa_carry(lvl1_sum_s, lvl1_carry_s, op4_s);
        sum_s        = ripple_add(lvl2_sum_s, lvl2_carry_s);
    end

    // Stage 1 register
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= {SW{1'b0}};
        end else begin
            sum_q <= sum_s;
        end
    end

    // Stage 2 combinational: truncating divide by four and strict compare
    always_comb begin
        avg_s = sum_q[SW-1:2];
        hot_s = (avg_s > temp_compare);
`ifdef TEMP_STICKY_EN
        hot_next_s = too_hot_r | hot_s;
`else
        hot_next_s = hot_s;
`endif
    end

    // Stage 2 output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            temp_avg_r <= {W{1'b0}};
            too_hot_r  <= 1'b0;
        end else begin
            temp_avg_r <= avg_s;
            too_hot_r  <= hot_next_s;
        end
    end

    assign temp_avg = temp_avg_r;
    assign tooHot   = too_hot_r;

endmodule

// File: tb/tb_temp_monitor.sv
// Directed, table-driven bench for temp_monitor (W=16), plus threshold, reset,
// sticky-flag and back-to-back pipelining sequences.
module tb_temp_monitor;

    localparam int W = 16;
    localparam int NV = 11;

    typedef struct {
        logic [W-1:0] t1;
        logic [W-1:0] t2;
        logic [W-1:0] t3;
        logic [W-1:0] t4;
        logic [W-1:0] thr;
        logic [W-1:0] avg;
        logic         hot;
    } vec_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] temp1, temp2, temp3, temp4, temp_compare;
    logic [W-1:0] temp_avg;
    logic         tooHot;

    int n_tests;
    int n_fail;
    vec_t tab [NV];

    temp_monitor #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .temp1       (temp1),
        .temp2       (temp2),
        .temp3       (temp3),
        .temp4       (temp4),
        .temp_compare(temp_compare),
        .temp_avg    (temp_avg),
        .tooHot      (tooHot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                         input logic [W-1:0] d, input logic [W-1:0] thr);
        temp1 = a; temp2 = b; temp3 = c; temp4 = d; temp_compare = thr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        tab[0]  = '{16'd100, 16'd101, 16'd99, 16'd98, 16'd96, 16'd99, 1'b1};
        tab[1]  = '{16'd96, 16'd96, 16'd96, 16'd96, 16'd96, 16'd96, 1'b0};
        tab[2]  = '{16'd96, 16'd96, 16'd96, 16'd96, 16'd95, 16'd96, 1'b1};
        tab[3]  = '{16'd97, 16'd97, 16'd97, 16'd98, 16'd97, 16'd97, 1'b0};
        tab[4]  = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFF, 1'b1};
        tab[5]  = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0};
        tab[6]  = '{16'd1, 16'd2, 16'd3, 16'd5, 16'd1, 16'd2, 1'b1};
        tab[7]  = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h3FFF, 16'h3FFF, 1'b0};
        tab[8]  = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFE, 1'b1};
        tab[9]  = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h8000, 1'b1};
        tab[10] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h7897, 16'h7896, 1'b0};

        rst = 1'b1;
        drive(16'd200, 16'd200, 16'd200, 16'd200, 16'd0);
        tick();
        tick();
        check("reset_avg", temp_avg, 16'd0);
        check("reset_hot", {15'd0, tooHot}, 16'd0);

        // Each vector from a fresh reset: zeroed pipeline after one edge, result after two
        for (int i = 0; i < NV; i++) begin
            rst = 1'b1;
            drive(tab[i].t1, tab[i].t2, tab[i].t3, tab[i].t4, tab[i].thr);
            tick();
            rst = 1'b0;
            tick();
            check($sformatf("v%0d_lat_avg", i), temp_avg, 16'd0);
            check($sformatf("v%0d_lat_hot", i), {15'd0, tooHot}, 16'd0);
            tick();
            check($sformatf("v%0d_avg", i), temp_avg, tab[i].avg);
            check($sformatf("v%0d_hot", i), {15'd0, tooHot}, {15'd0, tab[i].hot});
        end

        // Threshold is sampled by stage 2, so a change shows after one edge
        do_reset();
        drive(16'd96, 16'd96, 16'd96, 16'd96, 16'd96);
        tick(); tick(); tick();
        check("thr_eq_hot", {15'd0, tooHot}, 16'd0);
        temp_compare = 16'd95;
        tick();
        check("thr_drop_hot", {15'd0, tooHot}, 16'd1);
        tick();
        check("thr_drop_hot2", {15'd0, tooHot}, 16'd1);

        // Reset mid-operation, then recovery after exactly two edges
        do_reset();
        drive(16'd100, 16'd101, 16'd99, 16'd98, 16'd96);
        tick(); tick(); tick();
        check("pre_rst_hot", {15'd0, tooHot}, 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_avg", temp_avg, 16'd0);
        check("mid_rst_hot", {15'd0, tooHot}, 16'd0);
        tick();
        check("rec1_avg", temp_avg, 16'd0);
        check("rec1_hot", {15'd0, tooHot}, 16'd0);
        tick();
        check("rec2_avg", temp_avg, 16'd99);
        check("rec2_hot", {15'd0, tooHot}, 16'd1);

        // Temperature drop after over-temp: sticky build holds the flag
        drive(16'd50, 16'd50, 16'd50, 16'd50, 16'd96);
        tick();
        check("drop1_avg", temp_avg, 16'd99);
        check("drop1_hot", {15'd0, tooHot}, 16'd1);
        tick();
        check("drop2_avg", temp_avg, 16'd50);
`ifdef TEMP_STICKY_EN
        check("drop2_hot", {15'd0, tooHot}, 16'd1);
        temp_compare = 16'hFFFF;
        tick();
        check("sticky_thr_hot", {15'd0, tooHot}, 16'd1);
`else
        check("drop2_hot", {15'd0, tooHot}, 16'd0);
        temp_compare = 16'd49;
        tick();
        check("relow_thr_hot", {15'd0, tooHot}, 16'd1);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("drop_rst_hot", {15'd0, tooHot}, 16'd0);
        check("drop_rst_avg", temp_avg, 16'd0);

        // Back-to-back samples: one new average per cycle, two edges behind the inputs
        do_reset();
        for (int k = 0; k <= NV; k++) begin
            if (k < NV) begin
                drive(tab[k].t1, tab[k].t2, tab[k].t3, tab[k].t4, 16'd0);
            end else begin
                drive(16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
            end
            tick();
            if (k >= 1) begin
                check($sformatf("stream%0d_avg", k - 1), temp_avg, tab[k-1].avg);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
